// File: rtl/jt49_eg_pkg.sv
// Shared definitions for the jt49_eg_gen envelope generator.
// Bit positions inside the 4-bit shape control word and the envelope
// state encoding live here so the top and the bench agree on them.
package jt49_eg_pkg;

    // Shape control bit indices.
    localparam int CTRL_CONT = 3;
    localparam int CTRL_ATT  = 2;
    localparam int CTRL_ALT  = 1;
    localparam int CTRL_HOLD = 0;

    // Envelope state: RUN steps on prescaler ticks, HOLD freezes the level.
    typedef enum logic {
        EG_RUN  = 1'b0,
        EG_HOLD = 1'b1
    } eg_state_e;

endpackage

// File: rtl/jt49_eg_presc.sv
// Envelope period prescaler.
// Counts cen cycles and raises tick_o for one cycle every max(period,1)
// cen cycles. period_i is read live: if it shrinks below the current
// count, the next cen produces a tick. clear_i restarts the count.
module jt49_eg_presc #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_i,
    input  logic          clear_i,
    input  logic [PW-1:0] period_i,
    output logic          tick_o
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] limit;

    // Terminal count is max(period,1)-1, so period 0 behaves as period 1.
    always_comb begin
        limit = '0;
        if (period_i != '0) begin
            limit = period_i - {{(PW-1){1'b0}}, 1'b1};
        end
        tick_o = cen_i && (cnt_q >= limit);
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (cen_i) begin
            cnt_d = cnt_q + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jt49_eg_gen.sv
// AY-3-8910 compatible envelope generator with built-in period prescaler.
// Produces an EW-bit level following the 16 AY shapes. The level is
// step XOR {EW{inv}}, registered one clock after the tick or restart.
// Optional feature: define JT49_EG_CYCLE_EN to get the 'cycle' port, a
// one-clock strobe coincident with the env update at every end of a
// 2^EW-step cycle while running.
// Handshake: restart is a single-clock pulse with no ready; it is always
// accepted, latches ctrl and wins over a prescaler tick in the same clock.
// The FSM state is visible on dbg_state for checkers.
module jt49_eg_gen
    import jt49_eg_pkg::*;
#(
    parameter int EW = 5,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          restart,
    input  logic [3:0]    ctrl,
    input  logic [PW-1:0] period,
    output eg_state_e     dbg_state,
    output logic [EW-1:0] env
`ifdef JT49_EG_CYCLE_EN
    ,
    output logic          cycle
`endif
);

    localparam logic [EW-1:0] STEP_MAX = {EW{1'b1}};

    eg_state_e     state_q;
    logic [3:0]    ctrl_q;
    logic [EW-1:0] step_q;
    logic          inv_q;
    logic [EW-1:0] env_q;
    logic          tick;
    logic [EW-1:0] step_d;
    logic          inv_alt_d;
`ifdef JT49_EG_CYCLE_EN
    logic          cycle_q;
`endif

    jt49_eg_presc #(.PW(PW)) u_presc (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen_i    (cen),
        .clear_i  (restart),
        .period_i (period),
        .tick_o   (tick)
    );

    // Next step value and the inversion after an end-of-cycle alternate.
    always_comb begin
        step_d    = step_q + {{(EW-1){1'b0}}, 1'b1};
        inv_alt_d = inv_q ^ ctrl_q[CTRL_ALT];
    end

    // Envelope FSM: restart beats tick, reset beats both; outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EG_HOLD;
            ctrl_q  <= 4'b0000;
            step_q  <= '0;
            inv_q   <= 1'b0;
            env_q   <= '0;
`ifdef JT49_EG_CYCLE_EN
            cycle_q <= 1'b0;
`endif
        end else begin
`ifdef JT49_EG_CYCLE_EN
            cycle_q <= 1'b0;
`endif
            if (restart) begin
                ctrl_q  <= ctrl;
                step_q  <= '0;
                inv_q   <= ~ctrl[CTRL_ATT];
                state_q <= EG_RUN;
                env_q   <= {EW{~ctrl[CTRL_ATT]}};
            end else if (state_q == EG_RUN && tick) begin
                if (step_q != STEP_MAX) begin
                    step_q <= step_d;
                    env_q  <= step_d ^ {EW{inv_q}};
                end else begin
`ifdef JT49_EG_CYCLE_EN
                    cycle_q <= 1'b1;
`endif
                    if (!ctrl_q[CTRL_CONT]) begin
                        // One-shot shapes always end silent.
                        state_q <= EG_HOLD;
                        inv_q   <= 1'b1;
                        step_q  <= STEP_MAX;
                        env_q   <= '0;
                    end else if (ctrl_q[CTRL_HOLD]) begin
                        state_q <= EG_HOLD;
                        inv_q   <= inv_alt_d;
                        env_q   <= STEP_MAX ^ {EW{inv_alt_d}};
                    end else begin
                        step_q <= '0;
                        inv_q  <= inv_alt_d;
                        env_q  <= {EW{inv_alt_d}};
                    end
                end
            end
        end
    end

    assign dbg_state = state_q;
    assign env       = env_q;
`ifdef JT49_EG_CYCLE_EN
    assign cycle     = cycle_q;
`endif

endmodule

// File: tb/tb_jt49_eg_gen.sv
// Self-checking bench for jt49_eg_gen (EW=5, PW=16).
// The reference model counts accepted steps since restart and derives
// the level from the AY shape rules in closed form.
module tb_jt49_eg_gen;
  import jt49_eg_pkg::*;

  localparam int EW   = 5;
  localparam int PW   = 16;
  localparam int NLVL = 1 << EW;
  localparam int MAXV = NLVL - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b1;
  logic          restart = 1'b0;
  logic [3:0]    ctrl = 4'b0000;
  logic [PW-1:0] period = 16'd1;
  eg_state_e     dbg_state;
  logic [EW-1:0] env;
  logic          cycle;

  int errors = 0;
  int checks = 0;

  // model state
  int            m_k;
  int            m_cnt;
  logic [3:0]    m_ctrl;
  logic          m_active;
  logic [EW-1:0] m_env;
  logic          m_cycle;

  jt49_eg_gen #(.EW(EW), .PW(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .restart   (restart),
    .ctrl      (ctrl),
    .period    (period),
    .dbg_state (dbg_state),
    .env       (env)
`ifdef JT49_EG_CYCLE_EN
    ,
    .cycle     (cycle)
`endif
  );

`ifndef JT49_EG_CYCLE_EN
  assign cycle = 1'b0;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  // AY level after k steps from restart, for shape c
  function automatic logic [EW-1:0] shape_level(input logic [3:0] c, input int k);
    int cyc;
    int i;
    int lvl;
    logic dir;
    cyc = k / NLVL;
    i   = k % NLVL;
    if (!c[3]) begin
      lvl = (cyc == 0) ? (c[2] ? i : MAXV - i) : 0;
    end else if (c[0]) begin
      lvl = (cyc == 0) ? (c[2] ? i : MAXV - i) : ((c[2] ^ c[1]) ? MAXV : 0);
    end else begin
      dir = c[2] ^ (c[1] & cyc[0]);
      lvl = dir ? i : MAXV - i;
    end
    return lvl[EW-1:0];
  endfunction

  task automatic model_update();
    int peff;
    logic tick;
    if (!rst_n) begin
      m_k = 0; m_cnt = 0; m_ctrl = 4'b0000; m_active = 1'b0; m_env = '0; m_cycle = 1'b0;
    end else begin
      m_cycle = 1'b0;
      tick = 1'b0;
      if (cen) begin
        peff = (period == 0) ? 1 : int'(period);
        if (m_cnt + 1 >= peff) begin tick = 1'b1; m_cnt = 0; end
        else m_cnt = m_cnt + 1;
      end
      if (restart) begin
        m_ctrl = ctrl; m_k = 0; m_cnt = 0; m_active = 1'b1;
        m_env = shape_level(ctrl, 0);
      end else if (tick && m_active) begin
        m_k = m_k + 1;
        if (m_k % NLVL == 0) m_cycle = 1'b1;
        if (m_k == NLVL && (!m_ctrl[3] || m_ctrl[0])) m_active = 1'b0;
        m_env = shape_level(m_ctrl, m_k);
      end
    end
  endtask

  // driver: one clock, model follows the same sampled inputs
  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_restart(input logic [3:0] c);
    restart = 1'b1;
    ctrl = c;
    clk_step();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b1; restart = 1'b1; ctrl = 4'($urandom_range(0, 15));
    period = 16'($urandom_range(0, 5));
    clk_step(); clk_step();
    restart = 1'b0;
    checks++; if (env !== '0) begin errors++; $display("FAIL reset_env got=%0d exp=0", env); end
    checks++; if (dbg_state !== EG_HOLD) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, EG_HOLD); end
`ifdef JT49_EG_CYCLE_EN
    checks++; if (cycle !== 1'b0) begin errors++; $display("FAIL reset_cycle got=%0b exp=0", cycle); end
`endif
    rst_n = 1'b1; period = 16'd1;
    for (int n = 0; n < 8; n++) begin
      clk_step();
      checks++; if (env !== '0) begin errors++; $display("FAIL reset_idle_env n=%0d got=%0d exp=0", n, env); end
    end
  endtask

  task automatic test_decay();
    period = 16'd1; cen = 1'b1;
    do_restart(4'b0000);
    checks++; if (env !== 5'd31) begin errors++; $display("FAIL decay_first got=%0d exp=31", env); end
    for (int n = 0; n < 140; n++) begin
      clk_step();
      checks++; if (env !== m_env) begin errors++; $display("FAIL decay_env n=%0d got=%0d exp=%0d", n, env, m_env); end
      checks++; if (dbg_state !== (m_active ? EG_RUN : EG_HOLD)) begin errors++; $display("FAIL decay_state n=%0d got=%0d exp_active=%0b", n, dbg_state, m_active); end
    end
    checks++; if (env !== '0) begin errors++; $display("FAIL decay_final got=%0d exp=0", env); end
  endtask

  task automatic test_sawtooth();
    int pulses;
    pulses = 0;
    period = 16'd1; cen = 1'b1;
    do_restart(4'b1100);
    checks++; if (env !== '0) begin errors++; $display("FAIL saw_first got=%0d exp=0", env); end
    for (int n = 0; n < 100; n++) begin
      clk_step();
      if (cycle === 1'b1) pulses++;
      checks++; if (env !== m_env) begin errors++; $display("FAIL saw_env n=%0d got=%0d exp=%0d", n, env, m_env); end
`ifdef JT49_EG_CYCLE_EN
      checks++; if (cycle !== m_cycle) begin errors++; $display("FAIL saw_cycle n=%0d got=%0b exp=%0b", n, cycle, m_cycle); end
`endif
    end
`ifdef JT49_EG_CYCLE_EN
    checks++; if (pulses != 3) begin errors++; $display("FAIL saw_pulse_count got=%0d exp=3", pulses); end
`endif
  endtask

  task automatic test_triangle();
    period = 16'd1; cen = 1'b1;
    do_restart(4'b1110);
    for (int n = 0; n < 100; n++) begin
      clk_step();
      checks++; if (env !== m_env) begin errors++; $display("FAIL tri_env n=%0d got=%0d exp=%0d", n, env, m_env); end
    end
    do_restart(4'b1011);
    for (int n = 0; n < 60; n++) begin
      clk_step();
      checks++; if (env !== m_env) begin errors++; $display("FAIL hold_env n=%0d got=%0d exp=%0d", n, env, m_env); end
    end
    checks++; if (env !== 5'd31) begin errors++; $display("FAIL hold_final got=%0d exp=31", env); end
    checks++; if (dbg_state !== EG_HOLD) begin errors++; $display("FAIL hold_state got=%0d exp=%0d", dbg_state, EG_HOLD); end
  endtask

  task automatic test_period();
    cen = 1'b1;
    period = 16'd3;
    do_restart(4'b1100);
    for (int n = 0; n < 40; n++) begin
      clk_step();
      checks++; if (env !== m_env) begin errors++; $display("FAIL per3_env n=%0d got=%0d exp=%0d", n, env, m_env); end
    end
    period = 16'd0;
    do_restart(4'b1110);
    for (int n = 0; n < 40; n++) begin
      clk_step();
      checks++; if (env !== m_env) begin errors++; $display("FAIL per0_env n=%0d got=%0d exp=%0d", n, env, m_env); end
    end
    period = 16'd2;
    do_restart(4'b1101);
    for (int n = 0; n < 60; n++) begin
      cen = ~cen;
      clk_step();
      checks++; if (env !== m_env) begin errors++; $display("FAIL cen_env n=%0d got=%0d exp=%0d", n, env, m_env); end
    end
    cen = 1'b1;
  endtask

  task automatic test_restart_mid();
    logic found;
    found = 1'b0;
    cen = 1'b1; period = 16'd3;
    do_restart(4'b1100);
    for (int n = 0; n < 200 && !found; n++) begin
      clk_step();
      if (env === 5'd17) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_wait17 got=%0d exp=17", env); end
    do_restart(4'b1000);
    checks++; if (env !== 5'd31) begin errors++; $display("FAIL mid_restart got=%0d exp=31", env); end
    ctrl = 4'b0000;
    for (int n = 0; n < 120; n++) begin
      clk_step();
      checks++; if (env !== m_env) begin errors++; $display("FAIL mid_env n=%0d got=%0d exp=%0d", n, env, m_env); end
    end
    checks++; if (dbg_state !== EG_RUN) begin errors++; $display("FAIL mid_shape_kept got=%0d exp=%0d", dbg_state, EG_RUN); end
  endtask

  task automatic test_reset_mid();
    cen = 1'b1; period = 16'd1;
    do_restart(4'b1110);
    for (int n = 0; n < 45; n++) clk_step();
    rst_n = 1'b0;
    clk_step();
    rst_n = 1'b1;
    checks++; if (env !== '0) begin errors++; $display("FAIL rstmid_env got=%0d exp=0", env); end
`ifdef JT49_EG_CYCLE_EN
    checks++; if (cycle !== 1'b0) begin errors++; $display("FAIL rstmid_cycle got=%0b exp=0", cycle); end
`endif
    for (int n = 0; n < 50; n++) begin
      clk_step();
      checks++; if (env !== m_env) begin errors++; $display("FAIL rstmid_idle n=%0d got=%0d exp=%0d", n, env, m_env); end
    end
    checks++; if (env !== '0) begin errors++; $display("FAIL rstmid_final got=%0d exp=0", env); end
  endtask

  task automatic test_random();
    period = 16'd1;
    do_restart(4'($urandom_range(0, 15)));
    for (int n = 0; n < 2000; n++) begin
      cen     = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 59) == 0);
      ctrl    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) period = 16'($urandom_range(0, 4));
      clk_step();
      checks++; if (env !== m_env) begin errors++; $display("FAIL rnd_env n=%0d got=%0d exp=%0d", n, env, m_env); end
      checks++; if (dbg_state !== (m_active ? EG_RUN : EG_HOLD)) begin errors++; $display("FAIL rnd_state n=%0d got=%0d exp_active=%0b", n, dbg_state, m_active); end
`ifdef JT49_EG_CYCLE_EN
      checks++; if (cycle !== m_cycle) begin errors++; $display("FAIL rnd_cycle n=%0d got=%0b exp=%0b", n, cycle, m_cycle); end
`endif
    end
    restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decay();
    test_sawtooth();
    test_triangle();
    test_period();
    test_restart_mid();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
